// File: rtl/dma_pkg.sv
// Shared definitions for the DMA read path: descriptor layout, boundary size
// and the request-splitter state encoding.
package dma_pkg;

  localparam int DESC_W        = 28;
  localparam int DESC_ADDR_MSB = 27;
  localparam int DESC_ADDR_LSB = 10;
  localparam int DESC_LEN_MSB  = 9;
  localparam int DESC_LEN_LSB  = 0;

  localparam int ADDR_W      = DESC_ADDR_MSB - DESC_ADDR_LSB + 1;
  localparam int LEN_W       = DESC_LEN_MSB - DESC_LEN_LSB + 1;
  localparam int REM_W       = LEN_W + 1;
  localparam int BOUNDARY_DW = 1024;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  // A zero length field stands for a full 1024-DW transfer.
  function automatic logic [REM_W-1:0] decode_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? REM_W'(BOUNDARY_DW) : {1'b0, len};
  endfunction

endpackage

// File: rtl/dma_chunk_calc.sv
// Size of the next read request: the smallest of the remaining length, the
// maximum read size and the distance to the next 4 KB boundary.
module dma_chunk_calc
  import dma_pkg::*;
#(
  parameter int MAX_RD_DW = 128
) (
  input  logic [9:0]       addrLow_i,
  input  logic [REM_W-1:0] remDw_i,
  output logic [REM_W-1:0] chunk_o
);

  localparam logic [REM_W-1:0] MAX_DW = REM_W'(MAX_RD_DW);

  logic [REM_W-1:0] to_boundary;
  logic [REM_W-1:0] min_rem_max;

  always_comb begin
    to_boundary = REM_W'(BOUNDARY_DW) - {1'b0, addrLow_i};
    min_rem_max = (remDw_i < MAX_DW) ? remDw_i : MAX_DW;
    chunk_o     = (min_rem_max < to_boundary) ? min_rem_max : to_boundary;
  end

endmodule

// File: rtl/dma_rd_req_splitter.sv
// Pops read descriptors from the show-ahead FIFO and splits each into memory
// read requests bounded by MAX_RD_DW and by 4 KB address boundaries.
module dma_rd_req_splitter
  import dma_pkg::*;
#(
  parameter int MAX_RD_DW = 128
) (
  input  logic              clockCore,
  input  logic              resetCore,
  input  logic              fifoEmpty,
  input  logic [DESC_W-1:0] fifoData,
  output logic              fifoPop,
  output logic              reqValid,
  input  logic              reqReady,
  output logic [ADDR_W-1:0] reqAddr,
  output logic [LEN_W-1:0]  reqLen,
  output logic              descDone,
  output logic              busy,
  output state_e            dbgState
);

  // Handshake: a request transfers in every cycle where reqValid and reqReady
  // are both high; while reqValid is high and reqReady low, reqValid, reqAddr
  // and reqLen hold their values.

  state_e            state_q;
  logic [ADDR_W-1:0] curAddr_q, curAddr_d;
  logic [REM_W-1:0]  remDw_q, remDw_d;
  logic              descDone_q;

  logic [REM_W-1:0]  chunk;
  logic              handshake;
  logic              last_chunk;
  logic              capture;

  dma_chunk_calc #(
    .MAX_RD_DW (MAX_RD_DW)
  ) u_chunk_calc (
    .addrLow_i (curAddr_q[9:0]),
    .remDw_i   (remDw_q),
    .chunk_o   (chunk)
  );

  // A new descriptor is taken either from IDLE or on the final handshake of
  // the current one, which gives back-to-back descriptors without a bubble.
  always_comb begin
    handshake  = (state_q == ISSUE) && reqReady;
    last_chunk = (chunk == remDw_q);
    capture    = !fifoEmpty && ((state_q == IDLE) || (handshake && last_chunk));
    curAddr_d  = curAddr_q + ADDR_W'(chunk);
    remDw_d    = remDw_q - chunk;
  end

  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) begin
      state_q    <= IDLE;
      curAddr_q  <= '0;
      remDw_q    <= '0;
      descDone_q <= 1'b0;
    end else begin
      descDone_q <= handshake && last_chunk;
      if (capture) begin
        curAddr_q <= fifoData[DESC_ADDR_MSB:DESC_ADDR_LSB];
        remDw_q   <= decode_len(fifoData[DESC_LEN_MSB:DESC_LEN_LSB]);
        state_q   <= ISSUE;
      end else if (handshake) begin
        curAddr_q <= curAddr_d;
        remDw_q   <= remDw_d;
        if (last_chunk) begin
          state_q <= IDLE;
        end
      end
    end
  end

  // Reset gating keeps pop low while reset is held even with a non-empty FIFO.
  assign fifoPop  = capture && !resetCore;
  assign reqValid = (state_q == ISSUE);
  assign reqAddr  = curAddr_q;
  assign reqLen   = chunk[LEN_W-1:0];
  assign descDone = descDone_q;
  assign busy     = (state_q == ISSUE);
  assign dbgState = state_q;

  a_req_stable : assert property (
    @(posedge clockCore) disable iff (resetCore)
    (reqValid && !reqReady) |=> (reqValid && $stable(reqAddr) && $stable(reqLen))
  );

  a_no_underrun : assert property (
    @(posedge clockCore) disable iff (resetCore)
    !(fifoPop && fifoEmpty)
  );

endmodule

// File: tb/tb_dma_rd_req_splitter.sv
// Bench for dma_rd_req_splitter: behavioural show-ahead FIFO, request
// scoreboard, descriptor vector table and hand-written corner sequences.
module tb_dma_rd_req_splitter;
  import dma_pkg::*;

  localparam int MAX_RD_DW = 128;

  logic        clockCore = 1'b0;
  logic        resetCore;
  logic        fifoEmpty;
  logic [27:0] fifoData;
  logic        fifoPop;
  logic        reqValid;
  logic        reqReady;
  logic [17:0] reqAddr;
  logic [9:0]  reqLen;
  logic        descDone;
  logic        busy;
  state_e      dbgState;

  always #5 clockCore = ~clockCore;

  dma_rd_req_splitter #(
    .MAX_RD_DW (MAX_RD_DW)
  ) dut (
    .clockCore (clockCore),
    .resetCore (resetCore),
    .fifoEmpty (fifoEmpty),
    .fifoData  (fifoData),
    .fifoPop   (fifoPop),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqAddr   (reqAddr),
    .reqLen    (reqLen),
    .descDone  (descDone),
    .busy      (busy),
    .dbgState  (dbgState)
  );

  typedef struct {
    logic [17:0] addr;
    logic [9:0]  len;
    int          exp_chunks;
    logic [9:0]  exp_first;
  } vec_t;

  vec_t        vecs[10];
  logic [27:0] desc_q[$];
  logic [27:0] exp_q[$];
  logic [9:0]  hs_len_q[$];
  int          hs_cyc_q[$];
  int          pop_cyc_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          done_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic refresh_fifo();
    fifoEmpty = (desc_q.size() == 0);
    fifoData  = fifoEmpty ? 28'h0 : desc_q[0];
  endtask

  task automatic push_desc(input logic [17:0] addr, input logic [9:0] len);
    desc_q.push_back({addr, len});
    refresh_fifo();
  endtask

  // Reference split: walk the descriptor in the largest legal pieces.
  task automatic model_split(input logic [17:0] addr, input logic [9:0] len);
    int rem, a, c, room;
    rem = (len == 10'd0) ? 1024 : int'(len);
    a   = int'(addr);
    while (rem > 0) begin
      room = 1024 - (a % 1024);
      c = rem;
      if (c > MAX_RD_DW) c = MAX_RD_DW;
      if (c > room) c = room;
      exp_q.push_back({18'(a), 10'(c)});
      a = (a + c) % 262144;
      rem -= c;
    end
  endtask

  task automatic clear_logs();
    hs_len_q.delete();
    hs_cyc_q.delete();
    pop_cyc_q.delete();
    done_count = 0;
  endtask

  // One clock: observe at the falling edge, apply FIFO pop just after rising edge.
  task automatic step();
    logic        popped;
    logic [27:0] e;
    @(negedge clockCore);
    cycle++;
    check("pop_while_empty", 32'(fifoPop & fifoEmpty), 32'd0);
    if (reqValid && reqReady) begin
      hs_len_q.push_back(reqLen);
      hs_cyc_q.push_back(cycle);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req actual=0x%0h required=none", {reqAddr, reqLen});
      end else begin
        e = exp_q.pop_front();
        check("req_addr_len", 32'({reqAddr, reqLen}), 32'(e));
      end
    end
    if (descDone) done_count++;
    popped = fifoPop;
    if (popped) pop_cyc_q.push_back(cycle);
    @(posedge clockCore);
    #1;
    if (popped && desc_q.size() != 0) desc_q.delete(0);
    refresh_fifo();
  endtask

  task automatic drain(input bit rand_ready, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || desc_q.size() != 0) && n < budget) begin
      reqReady = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
      n++;
    end
    if (exp_q.size() != 0 || busy || desc_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
      exp_q.delete();
    end
    reqReady = 1'b0;
    step();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_fifoPop"},  32'(fifoPop),  32'd0);
    check({tag, "_reqValid"}, 32'(reqValid), 32'd0);
    check({tag, "_reqAddr"},  32'(reqAddr),  32'd0);
    check({tag, "_reqLen"},   32'(reqLen),   32'd0);
    check({tag, "_descDone"}, 32'(descDone), 32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_state"},    32'(dbgState), 32'(IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{18'h00000, 10'd256,  2, 10'd128};
    vecs[1] = '{18'h003F0, 10'd40,   2, 10'd16};
    vecs[2] = '{18'h00400, 10'd0,    8, 10'd128};
    vecs[3] = '{18'h3FFF0, 10'd32,   2, 10'd16};
    vecs[4] = '{18'h00100, 10'd8,    1, 10'd8};
    vecs[5] = '{18'h003FF, 10'd1,    1, 10'd1};
    vecs[6] = '{18'h003FF, 10'd2,    2, 10'd1};
    vecs[7] = '{18'h00050, 10'd300,  3, 10'd128};
    vecs[8] = '{18'h3FC00, 10'd0,    8, 10'd128};
    vecs[9] = '{18'h00380, 10'd1000, 8, 10'd128};

    resetCore = 1'b1;
    reqReady  = 1'b0;
    refresh_fifo();
    repeat (3) @(posedge clockCore);
    #1;
    check_idle("reset");
    resetCore = 1'b0;
    step();
    step();
    check_idle("post_reset");

    // Basic split with pop-to-valid latency and back-to-back chunks.
    clear_logs();
    model_split(18'h00000, 10'd256);
    push_desc(18'h00000, 10'd256);
    drain(1'b0, 50);
    check("basic_n_req", 32'(hs_cyc_q.size()), 32'd2);
    check("basic_n_pop", 32'(pop_cyc_q.size()), 32'd1);
    check("basic_done",  32'(done_count), 32'd1);
    if (hs_cyc_q.size() == 2 && pop_cyc_q.size() == 1) begin
      check("basic_latency", 32'(hs_cyc_q[0] - pop_cyc_q[0]), 32'd1);
      check("basic_gap",     32'(hs_cyc_q[1] - hs_cyc_q[0]),  32'd1);
    end

    // Descriptor table under random backpressure.
    for (int i = 0; i < 10; i++) begin
      clear_logs();
      model_split(vecs[i].addr, vecs[i].len);
      push_desc(vecs[i].addr, vecs[i].len);
      drain(1'b1, 400);
      check($sformatf("vec%0d_chunks", i), 32'(hs_len_q.size()), 32'(vecs[i].exp_chunks));
      if (hs_len_q.size() != 0)
        check($sformatf("vec%0d_first", i), 32'(hs_len_q[0]), 32'(vecs[i].exp_first));
      check($sformatf("vec%0d_done", i), 32'(done_count), 32'd1);
      check($sformatf("vec%0d_pops", i), 32'(pop_cyc_q.size()), 32'd1);
    end

    // Backpressure stall across the address wrap.
    clear_logs();
    model_split(18'h3FFF0, 10'd32);
    push_desc(18'h3FFF0, 10'd32);
    reqReady = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 32'(reqValid), 32'd1);
      check("stall_addr",  32'(reqAddr),  32'h3FFF0);
      check("stall_len",   32'(reqLen),   32'd16);
      check("stall_pop",   32'(fifoPop),  32'd0);
      step();
    end
    drain(1'b0, 50);
    check("wrap_n_req", 32'(hs_cyc_q.size()), 32'd2);
    check("wrap_done",  32'(done_count), 32'd1);

    // Two preloaded single-chunk descriptors: second pop on first handshake.
    clear_logs();
    model_split(18'h00100, 10'd8);
    model_split(18'h00200, 10'd8);
    push_desc(18'h00100, 10'd8);
    push_desc(18'h00200, 10'd8);
    drain(1'b0, 50);
    check("b2b_n_req", 32'(hs_cyc_q.size()), 32'd2);
    check("b2b_n_pop", 32'(pop_cyc_q.size()), 32'd2);
    check("b2b_done",  32'(done_count), 32'd2);
    if (hs_cyc_q.size() == 2 && pop_cyc_q.size() == 2) begin
      check("b2b_pop_on_hs", 32'(pop_cyc_q[1]), 32'(hs_cyc_q[0]));
      check("b2b_no_bubble", 32'(hs_cyc_q[1] - hs_cyc_q[0]), 32'd1);
    end

    // Asynchronous reset during a stalled request, FIFO still holding data.
    clear_logs();
    push_desc(18'h00100, 10'd64);
    push_desc(18'h00800, 10'd16);
    reqReady = 1'b0;
    step();
    step();
    check("pre_rst_valid", 32'(reqValid), 32'd1);
    check("pre_rst_busy",  32'(busy),     32'd1);
    #2;
    resetCore = 1'b1;
    #1;
    check_idle("rst_async");
    repeat (2) @(posedge clockCore);
    #1;
    desc_q.delete();
    refresh_fifo();
    resetCore = 1'b0;
    reqReady  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_idle("rst_release");
    end
    check("rst_no_req", 32'(hs_cyc_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
